// File: rtl/sdram_access_arbiter_if.sv
// Command-port bundle between the SDRAM access arbiter, its two burst requesters and the SDRAM core.
// The arbiter uses the slave view; the requesters and core side use the master view.
interface sdram_access_arbiter_if #(
    parameter int AddressWidthSDRAM = 24
);
    logic                         i_rd_req;
    logic [AddressWidthSDRAM-1:0] i_rd_addr;
    logic                         i_wr_req;
    logic [AddressWidthSDRAM-1:0] i_wr_addr;
    logic                         o_rd_ack;
    logic                         o_wr_ack;
    logic                         o_rd_active;
    logic                         o_wr_active;
    logic                         o_cmd_valid;
    logic                         o_cmd_write;
    logic                         o_cmd_refresh;
    logic [AddressWidthSDRAM-1:0] o_cmd_addr;
    logic                         i_cmd_ack;
    logic                         i_cmd_done;
    logic                         o_refresh_overrun;

    modport slave (
        input  i_rd_req, i_rd_addr, i_wr_req, i_wr_addr, i_cmd_ack, i_cmd_done,
        output o_rd_ack, o_wr_ack, o_rd_active, o_wr_active, o_cmd_valid,
               o_cmd_write, o_cmd_refresh, o_cmd_addr, o_refresh_overrun
    );

    modport master (
        output i_rd_req, i_rd_addr, i_wr_req, i_wr_addr, i_cmd_ack, i_cmd_done,
        input  o_rd_ack, o_wr_ack, o_rd_active, o_wr_active, o_cmd_valid,
               o_cmd_write, o_cmd_refresh, o_cmd_addr, o_refresh_overrun
    );
endinterface

// File: rtl/sdram_access_arbiter.sv
// Shares one SDRAM command port between read, write and periodic refresh; one burst in flight at a time.
// Priority: refresh, starved write, read, write. Refresh waits for the current burst to complete.
module sdram_access_arbiter #(
    parameter int AddressWidthSDRAM = 24,
    parameter int RefreshInterval   = 780,
    parameter int WrStarveLimit     = 4
) (
    input logic               CLK,
    input logic               RST,
    sdram_access_arbiter_if.slave bus
);
    localparam int RefCntW = (RefreshInterval > 1) ? $clog2(RefreshInterval) : 1;
    localparam int StarveW = (WrStarveLimit > 0) ? $clog2(WrStarveLimit + 1) : 1;
    localparam logic [RefCntW-1:0] RefReload = RefCntW'(RefreshInterval - 1);
    localparam logic [StarveW-1:0] StarveMax = StarveW'(WrStarveLimit);

    typedef enum logic [1:0] {IDLE, ISSUE, ACTIVE} state_t;
    typedef enum logic [1:0] {OWN_RD, OWN_WR, OWN_REF} owner_t;

    state_t             state;
    owner_t             owner;
    logic [RefCntW-1:0] ref_cnt;
    logic               ref_pending;
    logic [StarveW-1:0] starve_cnt;

    owner_t grant;
    logic   grant_any;
    logic   ref_expire;
    logic   ref_clear;

    always_comb begin
        grant_any = 1'b1;
        grant     = OWN_RD;
        if (ref_pending)
            grant = OWN_REF;
        else if (bus.i_wr_req && (starve_cnt == StarveMax))
            grant = OWN_WR;
        else if (bus.i_rd_req)
            grant = OWN_RD;
        else if (bus.i_wr_req)
            grant = OWN_WR;
        else
            grant_any = 1'b0;
    end

    assign ref_expire = (ref_cnt == '0);
    assign ref_clear  = (state == ISSUE) && bus.i_cmd_ack && (owner == OWN_REF);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state                 <= IDLE;
            owner                 <= OWN_RD;
            ref_cnt               <= RefReload;
            ref_pending           <= 1'b0;
            starve_cnt            <= '0;
            bus.o_rd_ack          <= 1'b0;
            bus.o_wr_ack          <= 1'b0;
            bus.o_rd_active       <= 1'b0;
            bus.o_wr_active       <= 1'b0;
            bus.o_cmd_valid       <= 1'b0;
            bus.o_cmd_write       <= 1'b0;
            bus.o_cmd_refresh     <= 1'b0;
            bus.o_cmd_addr        <= '0;
            bus.o_refresh_overrun <= 1'b0;
        end else begin
            bus.o_rd_ack <= 1'b0;
            bus.o_wr_ack <= 1'b0;

            // A new expiry wins over a same-cycle refresh acceptance; that case is not an overrun.
            if (ref_expire) begin
                ref_cnt     <= RefReload;
                ref_pending <= 1'b1;
                if (ref_pending && !ref_clear)
                    bus.o_refresh_overrun <= 1'b1;
            end else begin
                ref_cnt <= ref_cnt - 1'b1;
                if (ref_clear)
                    ref_pending <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (grant_any) begin
                        owner             <= grant;
                        state             <= ISSUE;
                        bus.o_cmd_valid   <= 1'b1;
                        bus.o_cmd_write   <= (grant == OWN_WR);
                        bus.o_cmd_refresh <= (grant == OWN_REF);
                        if (grant == OWN_RD)
                            bus.o_cmd_addr <= bus.i_rd_addr;
                        else if (grant == OWN_WR)
                            bus.o_cmd_addr <= bus.i_wr_addr;
                        else
                            bus.o_cmd_addr <= '0;
                    end
                end
                ISSUE: begin
                    // A done arriving together with the ack belongs to nothing yet and is dropped.
                    if (bus.i_cmd_ack) begin
                        state             <= ACTIVE;
                        bus.o_cmd_valid   <= 1'b0;
                        bus.o_cmd_write   <= 1'b0;
                        bus.o_cmd_refresh <= 1'b0;
                        bus.o_cmd_addr    <= '0;
                        if (owner == OWN_RD) begin
                            bus.o_rd_ack    <= 1'b1;
                            bus.o_rd_active <= 1'b1;
                            if (!bus.i_wr_req)
                                starve_cnt <= '0;
                            else if (starve_cnt != StarveMax)
                                starve_cnt <= starve_cnt + 1'b1;
                        end else if (owner == OWN_WR) begin
                            bus.o_wr_ack    <= 1'b1;
                            bus.o_wr_active <= 1'b1;
                            starve_cnt      <= '0;
                        end
                    end
                end
                ACTIVE: begin
                    if (bus.i_cmd_done) begin
                        state           <= IDLE;
                        bus.o_rd_active <= 1'b0;
                        bus.o_wr_active <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_access_arbiter.sv
// Bench for sdram_access_arbiter: scripted requesters and SDRAM core, with a command scoreboard
// plus an independent refresh timeline that predicts where refresh commands must appear.
module tb_sdram_access_arbiter;
    localparam int AW  = 24;
    localparam int RI  = 200;
    localparam int LIM = 4;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    sdram_access_arbiter_if #(.AddressWidthSDRAM(AW)) bus ();

    sdram_access_arbiter #(
        .AddressWidthSDRAM(AW),
        .RefreshInterval  (RI),
        .WrStarveLimit    (LIM)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    typedef struct packed {
        logic          write;
        logic          refresh;
        logic [AW-1:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   next_ref_edge = RI + 1;
    int   last_latency = 0;
    int   last_issue_cyc = 0;
    int   ref_seen = 0;

    // Posedges since the last reset edge; a refresh becomes winnable at edge k*RI+1.
    always @(posedge CLK) begin
        if (!RST) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {bus.o_rd_ack, bus.o_wr_ack, bus.o_rd_active, bus.o_wr_active,
                bus.o_cmd_valid, bus.o_cmd_write, bus.o_cmd_refresh,
                bus.o_refresh_overrun, bus.o_cmd_addr};
    endfunction

    function automatic logic [1:0] kind_bits(input exp_t e);
        if (e.refresh) return 2'b00;
        return e.write ? 2'b01 : 2'b10;
    endfunction

    task automatic push_exp(input logic w, input logic [AW-1:0] a);
        exp_t e;
        e.write   = w;
        e.refresh = 1'b0;
        e.addr    = a;
        exp_q.push_back(e);
    endtask

    task automatic apply_reset();
        RST            = 1'b0;
        bus.i_rd_req   = 1'b0;
        bus.i_wr_req   = 1'b0;
        bus.i_cmd_ack  = 1'b0;
        bus.i_cmd_done = 1'b0;
        repeat (3) @(negedge CLK);
        check_eq("reset_outs", outs(), 32'h0);
        RST           = 1'b1;
        next_ref_edge = RI + 1;
        exp_q.delete();
    endtask

    // Plays the SDRAM core for one command: wait, compare with scoreboard, ack, then complete.
    task automatic serve(input int ack_wait, input int done_wait, input bit drop_req,
                         input bit finish, input bit ack_with_done);
        exp_t e;
        int   n;
        bit   ok;
        @(negedge CLK);
        n = 0;
        while (!bus.o_cmd_valid && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        last_latency   = n;
        last_issue_cyc = cyc;
        if (!bus.o_cmd_valid) begin
            check_eq("cmd_wait_timeout", 32'd0, 32'd1);
            return;
        end
        if (cyc >= next_ref_edge) begin
            e.write = 1'b0; e.refresh = 1'b1; e.addr = '0;
        end else if (exp_q.size() == 0) begin
            check_eq("unexpected_cmd", 32'd1, 32'd0);
            e.write = 1'b0; e.refresh = 1'b0; e.addr = '0;
        end else begin
            e = exp_q.pop_front();
        end
        check_eq("cmd_write", bus.o_cmd_write, e.write);
        check_eq("cmd_refresh", bus.o_cmd_refresh, e.refresh);
        check_eq("cmd_addr", bus.o_cmd_addr, e.addr);
        ok = 1'b1;
        repeat (ack_wait) begin
            @(negedge CLK);
            if (!bus.o_cmd_valid || bus.o_cmd_addr != e.addr || bus.o_cmd_write != e.write) ok = 1'b0;
        end
        if (ack_wait > 0) check_eq("cmd_hold", ok, 1'b1);
        bus.i_cmd_ack  = 1'b1;
        bus.i_cmd_done = ack_with_done;
        @(negedge CLK);
        bus.i_cmd_ack  = 1'b0;
        bus.i_cmd_done = 1'b0;
        check_eq("ack_pulse", {bus.o_rd_ack, bus.o_wr_ack}, kind_bits(e));
        check_eq("active_on", {bus.o_rd_active, bus.o_wr_active}, kind_bits(e));
        check_eq("valid_drop", bus.o_cmd_valid, 1'b0);
        if (e.refresh) begin
            ref_seen++;
            next_ref_edge = ((cyc + RI - 1) / RI) * RI + 1;
        end
        if (drop_req) begin
            if (e.write) bus.i_wr_req = 1'b0;
            else if (!e.refresh) bus.i_rd_req = 1'b0;
        end
        if (!finish) return;
        @(negedge CLK);
        check_eq("ack_single", {bus.o_rd_ack, bus.o_wr_ack}, 2'b00);
        ok = 1'b1;
        repeat (done_wait - 2) begin
            @(negedge CLK);
            if ({bus.o_rd_active, bus.o_wr_active} != kind_bits(e) || bus.o_cmd_valid) ok = 1'b0;
        end
        check_eq("active_hold", ok, 1'b1);
        bus.i_cmd_done = 1'b1;
        @(negedge CLK);
        bus.i_cmd_done = 1'b0;
        check_eq("active_off", {bus.o_rd_active, bus.o_wr_active}, 2'b00);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_rd_req   = 1'b0;
        bus.i_rd_addr  = '0;
        bus.i_wr_req   = 1'b0;
        bus.i_wr_addr  = '0;
        bus.i_cmd_ack  = 1'b0;
        bus.i_cmd_done = 1'b0;
        apply_reset();

        // Stray completion while idle changes nothing
        bus.i_cmd_done = 1'b1;
        @(negedge CLK);
        bus.i_cmd_done = 1'b0;
        check_eq("idle_done", outs(), 32'h0);
        @(negedge CLK);
        check_eq("idle_done_settle", outs(), 32'h0);

        // Single read, ack held off, done coinciding with ack is ignored
        push_exp(1'b0, 24'h000100);
        bus.i_rd_addr = 24'h000100;
        bus.i_rd_req  = 1'b1;
        serve(3, 6, 1'b1, 1'b1, 1'b1);
        check_eq("rd_latency", last_latency, 32'd0);

        // Both requesters held: write forced after every LIM reads
        apply_reset();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < LIM; r++) push_exp(1'b0, 24'h0A0000);
            push_exp(1'b1, 24'h0B0000);
        end
        bus.i_rd_addr = 24'h0A0000;
        bus.i_wr_addr = 24'h0B0000;
        bus.i_rd_req  = 1'b1;
        bus.i_wr_req  = 1'b1;
        for (int t = 0; t < 2 * (LIM + 1); t++) serve(0, 8, 1'b0, 1'b1, 1'b0);
        bus.i_rd_req = 1'b0;
        bus.i_wr_req = 1'b0;
        check_eq("order_q_empty", exp_q.size(), 32'd0);

        // Continuous reads: exactly one refresh slips in between bursts
        apply_reset();
        ref_seen = 0;
        for (int t = 0; t < 25; t++) push_exp(1'b0, 24'h123456);
        bus.i_rd_addr = 24'h123456;
        bus.i_rd_req  = 1'b1;
        for (int t = 0; t < 26; t++) serve(0, 8, 1'b0, 1'b1, 1'b0);
        bus.i_rd_req = 1'b0;
        check_eq("refresh_count", ref_seen, 32'd1);
        check_eq("refresh_q_empty", exp_q.size(), 32'd0);
        check_eq("no_overrun", bus.o_refresh_overrun, 1'b0);

        // Ack withheld across two expiries: overrun sets and sticks
        apply_reset();
        push_exp(1'b0, 24'h000200);
        bus.i_rd_addr = 24'h000200;
        bus.i_rd_req  = 1'b1;
        serve(2 * RI + 10, 6, 1'b1, 1'b1, 1'b0);
        check_eq("overrun_set", bus.o_refresh_overrun, 1'b1);
        ref_seen = 0;
        serve(0, 4, 1'b0, 1'b1, 1'b0);
        check_eq("overrun_ref", ref_seen, 32'd1);
        push_exp(1'b1, 24'h000003);
        bus.i_wr_addr = 24'h000003;
        bus.i_wr_req  = 1'b1;
        serve(0, 4, 1'b1, 1'b1, 1'b0);
        check_eq("overrun_sticky", bus.o_refresh_overrun, 1'b1);

        // Reset during an active write, then refresh timing restarts
        apply_reset();
        push_exp(1'b1, 24'h0ABCDE);
        bus.i_wr_addr = 24'h0ABCDE;
        bus.i_wr_req  = 1'b1;
        serve(0, 0, 1'b1, 1'b0, 1'b0);
        RST = 1'b0;
        @(negedge CLK);
        check_eq("rst_mid_burst", outs(), 32'h0);
        RST           = 1'b1;
        next_ref_edge = RI + 1;
        exp_q.delete();
        ref_seen = 0;
        serve(0, 4, 1'b0, 1'b1, 1'b0);
        check_eq("ref_after_rst_cyc", last_issue_cyc, RI + 1);
        check_eq("ref_after_rst_seen", ref_seen, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sdram_access_arbiter.md
Name: sdram_access_arbiter

Overview:
- Shares the single SDRAM controller command port between three requesters: the frame-buffer write path (UART ingress), the frame-buffer read path (VGA scan-out), and an internal periodic refresh scheduler.
- Issues one burst command at a time over a valid/ack handshake and tracks it until the SDRAM core signals completion.
- Read has priority over write, with write anti-starvation. Refresh has highest priority but never pre-empts a burst in flight.

Parameters:
AddressWidthSDRAM, 24, width of burst start addresses
RefreshInterval, 780, clock cycles between refresh requests (7.8 us at 100 MHz)
WrStarveLimit, 4, consecutive read grants allowed while write is waiting before write is forced

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-low reset
i_rd_req  in  1  read burst request (level)
i_rd_addr  in  AddressWidthSDRAM  read burst start address, valid with i_rd_req
i_wr_req  in  1  write burst request (level)
i_wr_addr  in  AddressWidthSDRAM  write burst start address, valid with i_wr_req
o_rd_ack  out  1  one-cycle pulse: read command accepted by SDRAM core
o_wr_ack  out  1  one-cycle pulse: write command accepted by SDRAM core
o_rd_active  out  1  read burst owns the SDRAM (ack through done)
o_wr_active  out  1  write burst owns the SDRAM (ack through done)
o_cmd_valid  out  1  command valid to SDRAM core
o_cmd_write  out  1  1 = write burst, 0 = read burst or refresh
o_cmd_refresh  out  1  1 = auto-refresh command
o_cmd_addr  out  AddressWidthSDRAM  burst start address (0 for refresh)
i_cmd_ack  in  1  SDRAM core accepts command
i_cmd_done  in  1  one-cycle pulse: accepted command fully complete
o_refresh_overrun  out  1  sticky: a refresh came due while the previous one was still pending

Behaviour:
- Reset (RST=0 at clock edge):
  - State returns to IDLE. All outputs are 0.
  - Refresh pending flag is cleared; refresh down-counter loads RefreshInterval-1; starve counter is cleared.
  - Reset applied mid-burst abandons tracking with no completion pulse. The SDRAM core is reset on the same RST.
- Refresh scheduler (runs in every state):
  - Down-counter decrements each cycle.
  - At 0 it reloads RefreshInterval-1 and sets refresh_pending.
  - If refresh_pending is already 1 when the counter hits 0, o_refresh_overrun is set and stays set until reset.
- States: IDLE, ISSUE, ACTIVE.
- IDLE: arbitration is evaluated combinationally each cycle. Priority order:
  - (1) refresh_pending
  - (2) i_wr_req when starve count == WrStarveLimit
  - (3) i_rd_req
  - (4) i_wr_req
- IDLE, on a winner:
  - Register o_cmd_valid=1 with o_cmd_write, o_cmd_refresh and o_cmd_addr (requester address captured at this edge).
  - Record the owner; go to ISSUE. Latency from request to o_cmd_valid is 1 cycle.
- IDLE with no request: stay, o_cmd_valid=0.
- ISSUE:
  - Hold o_cmd_valid and all command fields stable until i_cmd_ack=1.
  - On the ack edge: o_cmd_valid→0, go to ACTIVE.
  - Pulse o_rd_ack or o_wr_ack for 1 cycle (none for refresh).
  - Assert o_rd_active or o_wr_active.
  - Clear refresh_pending if the owner is refresh.
- Starve count (updated at the ack edge):
  - Read accepted while i_wr_req=1: increment, saturating at WrStarveLimit.
  - Write accepted: clear to 0.
  - Read accepted with i_wr_req=0: clear to 0.
- Requester rule: deassert req the cycle after its ack. A req still high in IDLE is treated as a new request.
- ACTIVE:
  - Wait for i_cmd_done. On done: clear active flags, go to IDLE. The next arbitration is in the following cycle.
  - i_cmd_done in IDLE or ISSUE is ignored.
- Simultaneous events:
  - A refresh falling due during ACTIVE waits for done, then wins the next IDLE.
  - i_cmd_ack and i_cmd_done in the same ISSUE cycle: treated as ack only.
- Requests change only in IDLE arbitration. A request dropped while another owner is ACTIVE is simply lost (no latching).

Test Plan:
- Reset, then i_rd_req=1 addr 0x000100 → o_cmd_valid=1, o_cmd_write=0, addr 0x000100 one cycle later; hold until i_cmd_ack; o_rd_ack pulses once; o_rd_active high until i_cmd_done.
- i_rd_req and i_wr_req both held, core acks immediately and does done 8 cycles later → grant order R,R,R,R,W,R,R,R,R,W (WrStarveLimit=4); starve count clears after each W.
- RefreshInterval=50, continuous read traffic → refresh command (o_cmd_refresh=1, addr 0) issued at the first IDLE after the counter expires, never during ACTIVE; no o_rd_ack generated for it.
- RefreshInterval=20, i_cmd_ack withheld for 45 cycles on a read → o_refresh_overrun sets at the second expiry and stays 1 after traffic resumes.
- Drop RST low while ACTIVE on a write → next cycle all outputs 0, state IDLE; after release, the refresh counter restarts from RefreshInterval-1 (first refresh exactly RefreshInterval cycles later).
- i_cmd_done pulsed while IDLE with no requests → no state change, no acks, no o_cmd_valid.
